pc_next_unit: RTL and testbench

Program-counter register and branch-redirect unit for the LEGv8 core. It consumes the word-aligned branch offset produced by `shift_left2` (`SHIFT_OUT`) and the branch PC and condition flags from execute, and forms the taken target as branch PC + offset. It holds the architectural fetch PC and presents it to instruction fetch over a valid/ready handshake. Taken branches are redirected without ever changing a PC that is presented but not yet accepted.

---
 rtl/legv8_pkg.sv | 14 +
 rtl/branch_adder.sv | 12 +
 rtl/pc_next_unit.sv | 98 +++++++++
 tb/tb_pc_next_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 core types: address width, instruction size and PC-unit FSM states.
package legv8_pkg;

    typedef logic [63:0] addr_t;

    localparam addr_t INSTR_BYTES = 64'd4;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        PEND       = 2'd2
    } pc_state_t;

endpackage

// File: rtl/branch_adder.sv
// Combinational branch-target adder: branch PC plus word-aligned offset, wrapping modulo 2^64.
module branch_adder
    import legv8_pkg::*;
(
    input  addr_t branch_pc,
    input  addr_t branch_offset,
    output addr_t target
);

    assign target = branch_pc + branch_offset;

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register with valid/ready handshake and taken-branch redirect.
// A redirect that arrives while a presented PC is unaccepted is parked until fetch is free.
module pc_next_unit
    import legv8_pkg::*;
#(
    parameter addr_t RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        FETCH_READY,
    input  logic        BR_VALID,
    input  logic        UNCOND_BRANCH,
    input  logic        COND_BRANCH,
    input  logic        ZERO,
    input  logic [63:0] BRANCH_PC,
    input  logic [63:0] BRANCH_OFFSET,
    output logic [63:0] PC,
    output logic        PC_VALID,
    output logic        FLUSH
);

    pc_state_t state_q, state_d;
    addr_t     pc_q, pc_d;
    addr_t     pend_q, pend_d;
    logic      flush_q, flush_d;
    addr_t     target;

    logic accept;
    logic free;
    logic taken;

    branch_adder u_branch_adder (
        .branch_pc     (BRANCH_PC),
        .branch_offset (BRANCH_OFFSET),
        .target        (target)
    );

    assign PC_VALID = (state_q != RESET_HOLD) & ~STALL;
    assign accept   = PC_VALID & FETCH_READY;
    assign free     = ~PC_VALID | FETCH_READY;
    assign taken    = BR_VALID & (UNCOND_BRANCH | (COND_BRANCH & ZERO));

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        flush_d = 1'b0;

        unique case (state_q)
            RESET_HOLD: begin
                state_d = RUN;
            end
            RUN: begin
                if (taken && free) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end else if (taken) begin
                    pend_d  = target;
                    state_d = PEND;
                end else if (accept) begin
                    pc_d = pc_q + INSTR_BYTES;
                end
            end
            PEND: begin
                // Younger branches here are on the squashed path, so BR_VALID is ignored.
                if (free) begin
                    pc_d    = pend_q;
                    flush_d = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RESET_HOLD;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
        end
    end

    assign PC    = pc_q;
    assign FLUSH = flush_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed table-driven bench for pc_next_unit, plus hand sequences for PEND and reset.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic        br_valid;
    logic        uncond_branch;
    logic        cond_branch;
    logic        zero;
    logic [63:0] branch_pc;
    logic [63:0] branch_offset;
    logic [63:0] pc;
    logic        pc_valid;
    logic        flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic        unc;
        logic        cnd;
        logic        zero;
        logic [63:0] bpc;
        logic [63:0] boff;
        logic [63:0] exp_pc;
        logic        exp_valid;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[$];

    pc_next_unit #(.RESET_PC(64'h0)) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .STALL         (stall),
        .FETCH_READY   (fetch_ready),
        .BR_VALID      (br_valid),
        .UNCOND_BRANCH (uncond_branch),
        .COND_BRANCH   (cond_branch),
        .ZERO          (zero),
        .BRANCH_PC     (branch_pc),
        .BRANCH_OFFSET (branch_offset),
        .PC            (pc),
        .PC_VALID      (pc_valid),
        .FLUSH         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected values are the outputs seen after driving v, before the next edge.
    function automatic vec_t mk(input logic st, input logic rd, input logic br, input logic un,
                                input logic cn, input logic zr, input logic [63:0] bpc,
                                input logic [63:0] boff, input logic [63:0] epc,
                                input logic ev, input logic ef);
        vec_t v;
        v.stall = st; v.ready = rd; v.br = br; v.unc = un; v.cnd = cn; v.zero = zr;
        v.bpc = bpc; v.boff = boff; v.exp_pc = epc; v.exp_valid = ev; v.exp_flush = ef;
        return v;
    endfunction

    task automatic step(input string tag, input vec_t v);
        stall         = v.stall;
        fetch_ready   = v.ready;
        br_valid      = v.br;
        uncond_branch = v.unc;
        cond_branch   = v.cnd;
        zero          = v.zero;
        branch_pc     = v.bpc;
        branch_offset = v.boff;
        #1;
        check({tag, " pc"},    pc,               v.exp_pc);
        check({tag, " valid"}, {63'd0, pc_valid}, {63'd0, v.exp_valid});
        check({tag, " flush"}, {63'd0, flush},    {63'd0, v.exp_flush});
        @(posedge clk);
        #1;
    endtask

    // Shorthands: plain fetch, unconditional branch, conditional branch.
    function automatic vec_t seqv(input logic rd, input logic [63:0] epc, input logic ev, input logic ef);
        return mk(1'b0, rd, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, epc, ev, ef);
    endfunction

    function automatic vec_t bv(input logic rd, input logic [63:0] bpc, input logic [63:0] boff,
                                input logic [63:0] epc, input logic ef);
        return mk(1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0, bpc, boff, epc, 1'b1, ef);
    endfunction

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; fetch_ready = 1'b1; br_valid = 1'b0; uncond_branch = 1'b0;
        cond_branch = 1'b0; zero = 1'b0; branch_pc = '0; branch_offset = '0;

        // Sequential fetch from reset up to 0x20.
        vecs.push_back(seqv(1'b1, 64'h0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) vecs.push_back(seqv(1'b1, 64'(i * 4), 1'b1, 1'b0));
        vecs.push_back(bv(1'b1, 64'h18, 64'h40, 64'h20, 1'b0));
        vecs.push_back(seqv(1'b1, 64'h58, 1'b1, 1'b1));
        // CBZ not taken, then CBZ taken with negative offset.
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 64'h5C, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 64'h60, 1'b1, 1'b0));
        vecs.push_back(seqv(1'b1, 64'hF0, 1'b1, 1'b1));
        // STALL with ready: no increment; redirect under STALL loads at once.
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'hF4, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h200, 64'h8, 64'hF4, 1'b0, 1'b0));
        vecs.push_back(seqv(1'b1, 64'h208, 1'b1, 1'b1));
        // Back-to-back taken branches: FLUSH high two cycles.
        vecs.push_back(bv(1'b1, 64'h300, 64'h0, 64'h20C, 1'b0));
        vecs.push_back(bv(1'b1, 64'h400, 64'h4, 64'h300, 1'b1));
        vecs.push_back(seqv(1'b1, 64'h404, 1'b1, 1'b1));
        // Target near the top of memory, then PC+4 wraps to 0.
        vecs.push_back(bv(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4, 64'h408, 1'b0));
        vecs.push_back(seqv(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1));
        vecs.push_back(seqv(1'b1, 64'h0, 1'b1, 1'b0));
        // Target add wraps too: 0xFFF...F0 + 0x10 = 0.
        vecs.push_back(bv(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h4, 1'b0));
        vecs.push_back(seqv(1'b0, 64'h0, 1'b1, 1'b1));

        #12;
        check("reset pc",    pc, 64'h0);
        check("reset valid", {63'd0, pc_valid}, 64'd0);
        check("reset flush", {63'd0, flush},    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

        // Redirect to 0x40, then a redirect blocked by FETCH_READY=0 for three cycles.
        step("goto40",  bv(1'b1, 64'h40, 64'h0, 64'h0, 1'b0));
        step("pend0",   bv(1'b0, 64'h80, 64'h10, 64'h40, 1'b1));
        step("pend1",   bv(1'b0, 64'h500, 64'h0, 64'h40, 1'b0));
        step("pend2",   seqv(1'b0, 64'h40, 1'b1, 1'b0));
        step("release", seqv(1'b1, 64'h40, 1'b1, 1'b0));
        step("redir",   seqv(1'b1, 64'h90, 1'b1, 1'b1));
        step("after",   seqv(1'b1, 64'h94, 1'b1, 1'b0));

        // Reset in PEND drops the parked target.
        step("pendrst", bv(1'b0, 64'h700, 64'h0, 64'h98, 1'b0));
        step("inpend",  seqv(1'b0, 64'h98, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst pc",    pc, 64'h0);
        check("midrst valid", {63'd0, pc_valid}, 64'd0);
        check("midrst flush", {63'd0, flush},    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post0", seqv(1'b1, 64'h0, 1'b0, 1'b0));
        step("post1", seqv(1'b1, 64'h0, 1'b1, 1'b0));
        step("post2", seqv(1'b1, 64'h4, 1'b1, 1'b0));
        step("post3", seqv(1'b1, 64'h8, 1'b1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
